// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO round-robin drain scheduler.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } arb_state_e;

  // Width of a source index; never below 1 bit.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value BURST.
  function automatic int unsigned burst_cnt_w(input int unsigned b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational round-robin picker: first requesting index after 'last', wrapping.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;

  // Scan last+1 .. last+NUM_SRC (mod NUM_SRC); the first hit wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = IDX_W'((32'(last) + k) % NUM_SRC);
      if (!any_req && req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin read scheduler draining NUM_SRC capture FIFOs into one
// valid/ready word sink, at most BURST words per grant.
// Optional macro FIFO_SRC_TAG_EN adds the out_src source-index port.
module fifo_rr_drain
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BURST   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_empty,
  output logic [NUM_SRC-1:0]         src_rd_en,
  input  logic [NUM_SRC*WIDTH-1:0]   src_rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
`ifdef FIFO_SRC_TAG_EN
  ,
  output logic [src_idx_w(NUM_SRC)-1:0] out_src
`endif
);

  localparam int unsigned SRC_IDX_W   = src_idx_w(NUM_SRC);
  localparam int unsigned BURST_CNT_W = burst_cnt_w(BURST);
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST - 1);
  localparam logic [SRC_IDX_W-1:0]   LAST_SRC   = SRC_IDX_W'(NUM_SRC - 1);

  arb_state_e             state;
  logic [SRC_IDX_W-1:0]   grant;
  logic [SRC_IDX_W-1:0]   last_grant;
  logic [SRC_IDX_W-1:0]   pick_idx;
  logic                   pick_any;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [WIDTH-1:0]       rd_word;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (SRC_IDX_W)
  ) u_pick (
    .req     (~src_empty),
    .last    (last_grant),
    .grant   (pick_idx),
    .any_req (pick_any)
  );

  assign rd_word = src_rd_data[32'(grant)*WIDTH +: WIDTH];
  assign busy    = (state != IDLE);

  // Arbitration FSM. src_rd_en is registered on the transition into ISSUE
  // so the pulse coincides exactly with the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_rd_en  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      grant      <= '0;
      last_grant <= LAST_SRC;
      burst_cnt  <= '0;
`ifdef FIFO_SRC_TAG_EN
      out_src    <= '0;
`endif
    end else begin
      src_rd_en <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_idx;
            burst_cnt <= '0;
            src_rd_en <= NUM_SRC'(1) << pick_idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= rd_word;
          out_valid <= 1'b1;
`ifdef FIFO_SRC_TAG_EN
          out_src   <= grant;
`endif
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BURST_LAST || src_empty[grant]) begin
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              src_rd_en <= NUM_SRC'(1) << grant;
              state     <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench for fifo_rr_drain: queue-based FIFO sources, and a
// burst/round-robin reference model checked on every falling edge.
module tb_fifo_rr_drain;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned BURST   = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_SRC-1:0]       src_empty = '1;
  logic [NUM_SRC-1:0]       src_rd_en;
  logic [NUM_SRC*WIDTH-1:0] src_rd_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [WIDTH-1:0]         out_data;
  logic                     busy;
`ifdef FIFO_SRC_TAG_EN
  logic [1:0]               out_src;
`endif

  always #5 clk = ~clk;

  fifo_rr_drain #(
    .NUM_SRC (NUM_SRC),
    .WIDTH   (WIDTH),
    .BURST   (BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_empty   (src_empty),
    .src_rd_en   (src_rd_en),
    .src_rd_data (src_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
`ifdef FIFO_SRC_TAG_EN
    ,
    .out_src     (out_src)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source FIFO contents
  logic [WIDTH-1:0] fq [NUM_SRC][$];

  // Values the DUT sampled at the most recent rising edge
  logic               s_rst   = 1'b1;
  logic               s_ready = 1'b0;
  logic [NUM_SRC-1:0] s_empty = '1;

  // Reference model: idle/burst bookkeeping and a 2-cycle issue->valid delay
  bit               m_idle  = 1'b1;
  bit               m_valid = 1'b0;
  bit               s1 = 1'b0, s2 = 1'b0;
  int               m_last  = NUM_SRC - 1;
  int               m_cur   = 0;
  int               m_words = 0;
  logic [WIDTH-1:0] m_word  = '0;
  int               grants[$];
  int               lens[$];
  int               pulses[NUM_SRC];
  int               accepts = 0;

  function automatic int rr_next(input logic [NUM_SRC-1:0] nonempty, input int last);
    for (int k = 1; k <= NUM_SRC; k++)
      if (nonempty[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NUM_SRC; i++)
      if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Model step, output checks, then FIFO model reaction to src_rd_en
  always @(negedge clk) begin
    logic [NUM_SRC-1:0] exp_rd;
    bit                 issue;
    bit                 accept;
    int                 g;
    exp_rd = '0;
    issue  = 1'b0;
    accept = 1'b0;
    if (s_rst) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      s1 = 1'b0;
      s2 = 1'b0;
      m_last  = NUM_SRC - 1;
      m_words = 0;
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
`ifdef FIFO_SRC_TAG_EN
      check_eq("rst_src", out_src, 0);
`endif
    end else begin
      accept = m_valid && s_ready;
      if (m_idle) begin
        g = rr_next(~s_empty, m_last);
        if (g >= 0) begin
          exp_rd[g] = 1'b1;
          issue     = 1'b1;
          m_idle    = 1'b0;
          m_cur     = g;
          m_words   = 0;
          if (fq[g].size() > 0) m_word = fq[g][0];
          grants.push_back(g);
        end
      end else if (accept) begin
        m_words++;
        accepts++;
        if (m_words == BURST || s_empty[m_cur]) begin
          m_idle = 1'b1;
          m_last = m_cur;
          lens.push_back(m_words);
        end else begin
          exp_rd[m_cur] = 1'b1;
          issue = 1'b1;
          if (fq[m_cur].size() > 0) m_word = fq[m_cur][0];
        end
      end
      m_valid = (m_valid && !accept) || s2;
      s2 = s1;
      s1 = issue;
      check_eq("valid", out_valid, m_valid);
      if (m_valid) begin
        check_eq("data", out_data, m_word);
`ifdef FIFO_SRC_TAG_EN
        check_eq("src_tag", out_src, m_cur);
`endif
      end
    end
    check_eq("rd_en", src_rd_en, exp_rd);
    check_eq("busy", busy, !m_idle);

    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_rd_en[i]) begin
        pulses[i]++;
        if (fq[i].size() > 0) src_rd_data[i*WIDTH +: WIDTH] = fq[i].pop_front();
      end
    end
    for (int i = 0; i < NUM_SRC; i++) src_empty[i] = (fq[i].size() == 0);
    s_rst   = rst;
    s_ready = out_ready;
    s_empty = src_empty;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      logic [5:0] r;
      r = 6'($urandom);
      fq[s].push_back({2'(s), r});
    end
  endtask

  task automatic clear_log();
    grants.delete();
    lens.delete();
    for (int i = 0; i < NUM_SRC; i++) pulses[i] = 0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int t;
    t = 0;
    while (!(all_empty() && m_idle && !m_valid) && t < limit) begin
      tick();
      t++;
    end
    check_eq(tag, (t < limit), 1);
  endtask

  task automatic wait_rd_en(input string tag);
    int t;
    t = 0;
    while (src_rd_en == '0 && t < 100) begin
      tick();
      t++;
    end
    check_eq(tag, (src_rd_en != '0), 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int acc0;
    int psum;
    int exp_order[5];
    logic [WIDTH-1:0] d0;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with every source non-empty
    push(0, 1); push(1, 1); push(2, 1); push(3, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t1_rst_rd_en", src_rd_en, 0);
      check_eq("t1_rst_busy", busy, 0);
    end
    rst = 1'b0;
    wait_drain("t1_drain", 200);
    check_eq("t1_grants", grants.size(), 4);

    // Single source, three words
    clear_log();
    acc0 = accepts;
    fq[2].push_back(8'hA1);
    fq[2].push_back(8'hB2);
    fq[2].push_back(8'hC3);
    wait_drain("t2_drain", 200);
    check_eq("t2_ngrant", grants.size(), 1);
    if (grants.size() > 0) check_eq("t2_grant", grants[0], 2);
    check_eq("t2_pulses", pulses[2], 3);
    check_eq("t2_words", accepts - acc0, 3);

    // Round robin, full bursts
    pulse_rst();
    clear_log();
    for (int s = 0; s < NUM_SRC; s++) push(s, 20);
    wait_drain("t3_drain", 1000);
    check_eq("t3_ngrant", grants.size(), 12);
    for (int i = 0; i < 5; i++)
      if (grants.size() > i) check_eq("t3_order", grants[i], exp_order[i]);
    for (int i = 0; i < 4; i++)
      if (lens.size() > i) check_eq("t3_burst_len", lens[i], BURST);

    // Backpressure in SEND
    clear_log();
    acc0 = accepts;
    push(1, 5);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 100) begin
        tick();
        t++;
      end
      check_eq("t4_valid_seen", out_valid, 1);
    end
    out_ready = 1'b0;
    d0   = out_data;
    psum = pulses[0] + pulses[1] + pulses[2] + pulses[3];
    repeat (10) tick();
    check_eq("t4_hold_data", out_data, d0);
    check_eq("t4_hold_valid", out_valid, 1);
    check_eq("t4_no_rd", pulses[0] + pulses[1] + pulses[2] + pulses[3], psum);
    out_ready = 1'b1;
    wait_drain("t4_drain", 200);
    check_eq("t4_words", accepts - acc0, 5);

    // Wrap past 0 from last_grant=3; late source 0 waits its turn
    pulse_rst();
    clear_log();
    push(1, 3);
    wait_rd_en("t5_issue");
    push(0, 4);
    wait_drain("t5_drain", 200);
    check_eq("t5_ngrant", grants.size(), 2);
    if (grants.size() > 1) begin
      check_eq("t5_first", grants[0], 1);
      check_eq("t5_second", grants[1], 0);
    end

    // Reset in CAPTURE abandons the fetched word
    clear_log();
    push(3, 4);
    wait_rd_en("t6_issue");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_valid", out_valid, 0);
    check_eq("t6_busy", busy, 0);
`ifdef FIFO_SRC_TAG_EN
    check_eq("t6_src", out_src, 0);
`endif
    acc0 = accepts;
    wait_drain("t6_drain", 200);
    check_eq("t6_words", accepts - acc0, 3);

    // Randomized traffic, backpressure and occasional resets
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) push($urandom_range(0, NUM_SRC - 1), $urandom_range(1, 5));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    wait_drain("t7_drain", 6000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
